// File: rtl/pulseox_pkg.sv
// Shared constants and types for the pulse-oximeter FFT post-processing path.
// The frame length and heart-rate bin window are chosen for a 40 sps stream
// with a 1024-point CFFT: bin 13 is about 0.5 Hz and bin 90 about 3.5 Hz.
package pulseox_pkg;

  localparam int FFT_N     = 1024;
  localparam int SAMPLE_W  = 22;
  localparam int FFT_OUT_W = 24;
  localparam int HR_BIN_LO = 13;
  localparam int HR_BIN_HI = 90;

  // Frame-handling states of the post-FFT buffer
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } pdb_state_e;

endpackage

// File: rtl/cplx_mag_sat.sv
// Combinational L1 magnitude estimate |re| + |im| of one complex sample,
// clamped to the largest unsigned OUT_W value. The absolute values and the
// sum are formed at IN_W+1 bits, so the most negative input is handled
// exactly and the sum of two such magnitudes cannot overflow.
// Requires OUT_W <= IN_W.
module cplx_mag_sat #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 22
) (
  input  logic signed [IN_W-1:0]  re,
  input  logic signed [IN_W-1:0]  im,
  output logic        [OUT_W-1:0] mag
);

  logic signed [IN_W:0] re_ext;
  logic signed [IN_W:0] im_ext;
  logic        [IN_W:0] abs_re;
  logic        [IN_W:0] abs_im;
  logic        [IN_W:0] mag_sum;

  assign re_ext = {re[IN_W-1], re};
  assign im_ext = {im[IN_W-1], im};

  // Absolute values, sum, and clamp to the output range
  always_comb begin
    abs_re  = re_ext[IN_W] ? -re_ext : re_ext;
    abs_im  = im_ext[IN_W] ? -im_ext : im_ext;
    mag_sum = abs_re + abs_im;
    if (|mag_sum[IN_W:OUT_W]) begin
      mag = '1;
    end else begin
      mag = mag_sum[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fft_post_data_buffer.sv
// Consumer end of the CFFT output stream. Counts one N-beat frame, keeps the
// bin-0 magnitude as the DC component and the strongest magnitude inside the
// heart-rate window as the AC component, then publishes both with a one-cycle
// valid pulse. pdb_done tells the sample-side buffer when it may start the
// next frame. Bins N/2..N-1 mirror the lower half and are counted but ignored.
module fft_post_data_buffer
  import pulseox_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int IN_W   = FFT_OUT_W,
  parameter int OUT_W  = SAMPLE_W,
  parameter int BIN_LO = HR_BIN_LO,
  parameter int BIN_HI = HR_BIN_HI
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fft_out_data,
  input  logic signed [IN_W-1:0]  Iout,
  input  logic signed [IN_W-1:0]  Qout,
  output logic                    pdb_done,
  output logic        [OUT_W-1:0] AC_component,
  output logic        [OUT_W-1:0] DC_component,
  output logic [$clog2(N)-1:0]    peak_bin,
  output logic                    new_comp_DV
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIN = CW'(N - 1);
  localparam logic [CW-1:0] LO_BIN   = CW'(BIN_LO);
  localparam logic [CW-1:0] HI_BIN   = CW'(BIN_HI);

  pdb_state_e state;
  pdb_state_e state_next;

  logic [CW-1:0]    bin_cnt;
  logic [OUT_W-1:0] beat_mag;
  logic [OUT_W-1:0] run_dc;
  logic [OUT_W-1:0] run_max;
  logic [CW-1:0]    run_idx;

  logic start_frame;
  logic take_beat;
  logic last_beat;
  logic in_window;

  cplx_mag_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_mag (
    .re  (Iout),
    .im  (Qout),
    .mag (beat_mag)
  );

  assign in_window = (bin_cnt >= LO_BIN) && (bin_cnt <= HI_BIN);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-cycle datapath strobes
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    take_beat   = 1'b0;
    last_beat   = 1'b0;
    case (state)
      IDLE: begin
        if (fft_out_data) begin
          start_frame = 1'b1;
          state_next  = COLLECT;
        end
      end
      COLLECT: begin
        if (fft_out_data) begin
          take_beat = 1'b1;
          if (bin_cnt == LAST_BIN) begin
            last_beat  = 1'b1;
            state_next = REPORT;
          end
        end
      end
      REPORT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Running DC, windowed peak search and bin counter for the frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_cnt <= '0;
      run_dc  <= '0;
      run_max <= '0;
      run_idx <= LO_BIN;
    end else begin
      if (start_frame) begin
        run_dc  <= beat_mag;
        run_max <= '0;
        run_idx <= LO_BIN;
        bin_cnt <= CW'(1);
      end
      if (take_beat) begin
        if (last_beat) begin
          bin_cnt <= '0;
        end else begin
          bin_cnt <= bin_cnt + CW'(1);
        end
        if (in_window && (beat_mag > run_max)) begin
          run_max <= beat_mag;
          run_idx <= bin_cnt;
        end
      end
    end
  end

  // Published results, valid pulse and frame handshake to the sample buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdb_done     <= 1'b1;
      AC_component <= '0;
      DC_component <= '0;
      peak_bin     <= LO_BIN;
      new_comp_DV  <= 1'b0;
    end else begin
      new_comp_DV <= 1'b0;
      if (start_frame) begin
        pdb_done <= 1'b0;
      end
      if (last_beat) begin
        AC_component <= run_max;
        DC_component <= run_dc;
        peak_bin     <= run_idx;
        new_comp_DV  <= 1'b1;
      end
      if (state == REPORT) begin
        pdb_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_post_data_buffer.sv
// Bench for fft_post_data_buffer. Frames are described as I/Q arrays; the
// expected DC/AC/peak for each frame comes from a plain arithmetic model and
// is queued when the last beat is issued. A monitor pops the queue on every
// result pulse, so stimulus and checking run independently.
module tb_fft_post_data_buffer;

  localparam int N      = 1024;
  localparam int IN_W   = 24;
  localparam int OUT_W  = 22;
  localparam int BIN_LO = 13;
  localparam int BIN_HI = 90;
  localparam int CW     = $clog2(N);
  localparam longint MAG_MAX = (longint'(1) << OUT_W) - 1;

  typedef struct {
    longint ac;
    longint dc;
    longint peak;
    longint dv_cyc;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   fft_out_data;
  logic signed [IN_W-1:0] Iout;
  logic signed [IN_W-1:0] Qout;
  logic                   pdb_done;
  logic [OUT_W-1:0]       AC_component;
  logic [OUT_W-1:0]       DC_component;
  logic [CW-1:0]          peak_bin;
  logic                   new_comp_DV;

  int   frame_i [N];
  int   frame_q [N];
  exp_t sb [$];
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   dv_seen       = 0;
  int   frames_sent   = 0;
  int   cyc           = 0;

  fft_post_data_buffer #(
    .N      (N),
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .BIN_LO (BIN_LO),
    .BIN_HI (BIN_HI)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fft_out_data (fft_out_data),
    .Iout         (Iout),
    .Qout         (Qout),
    .pdb_done     (pdb_done),
    .AC_component (AC_component),
    .DC_component (DC_component),
    .peak_bin     (peak_bin),
    .new_comp_DV  (new_comp_DV)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks_total++;
    if (actual == expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint refMag(input int i, input int q);
    longint ai;
    longint aq;
    longint m;
    ai = (i < 0) ? -longint'(i) : longint'(i);
    aq = (q < 0) ? -longint'(q) : longint'(q);
    m  = ai + aq;
    return (m > MAG_MAX) ? MAG_MAX : m;
  endfunction

  // Reference: DC is bin 0, AC is the first strictly largest magnitude in the window
  function automatic exp_t refFrame();
    exp_t e;
    longint m;
    e.dc     = refMag(frame_i[0], frame_q[0]);
    e.ac     = 0;
    e.peak   = BIN_LO;
    e.dv_cyc = 0;
    for (int b = BIN_LO; b <= BIN_HI; b++) begin
      m = refMag(frame_i[b], frame_q[b]);
      if (m > e.ac) begin
        e.ac   = m;
        e.peak = b;
      end
    end
    return e;
  endfunction

  task automatic clearFrame();
    for (int b = 0; b < N; b++) begin
      frame_i[b] = 0;
      frame_q[b] = 0;
    end
  endtask

  task automatic randomFrame(input int range);
    for (int b = 0; b < N; b++) begin
      frame_i[b] = int'($urandom_range(0, 2 * range - 1)) - range;
      frame_q[b] = int'($urandom_range(0, 2 * range - 1)) - range;
    end
  endtask

  // Drive one frame; abort_after >= 0 hits reset after that many beats
  task automatic applyStimulus(input int max_gap, input int abort_after);
    exp_t e;
    e = refFrame();
    checkOutput("pdb_done_before_frame", longint'(pdb_done), 1);
    for (int b = 0; b < N; b++) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          @(negedge clk);
          fft_out_data = 1'b0;
          Iout = 24'($urandom);
          Qout = 24'($urandom);
        end
      end
      if (abort_after >= 0 && b == abort_after) begin
        @(negedge clk);
        fft_out_data = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_ac", longint'(AC_component), 0);
        checkOutput("rst_mid_dc", longint'(DC_component), 0);
        checkOutput("rst_mid_peak", longint'(peak_bin), BIN_LO);
        checkOutput("rst_mid_dv", longint'(new_comp_DV), 0);
        checkOutput("rst_mid_pdb_done", longint'(pdb_done), 1);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      fft_out_data = 1'b1;
      Iout = 24'(frame_i[b]);
      Qout = 24'(frame_q[b]);
      if (b == 2) begin
        checkOutput("pdb_done_in_frame", longint'(pdb_done), 0);
      end
      if (b == N - 1) begin
        @(posedge clk);
        #1;
        e.dv_cyc = cyc;
        sb.push_back(e);
        frames_sent++;
      end
    end
    @(negedge clk);
    fft_out_data = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pdb_done_after_frame", longint'(pdb_done), 1);
  endtask

  task automatic peakFrame();
    clearFrame();
    frame_i[40]  = -3000;
    frame_q[40]  = 4000;
    frame_i[100] = 9000;
    frame_i[600] = 20000;
  endtask

  // Monitor: every result pulse must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (new_comp_DV === 1'b1) begin
        dv_seen++;
        if (sb.size() == 0) begin
          checks_total++;
          $display("[TB] FAIL unexpected_dv: pulse at cycle %0d, expected no pulse", cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("dc_component", longint'(DC_component), e.dc);
          checkOutput("ac_component", longint'(AC_component), e.ac);
          checkOutput("peak_bin", longint'(peak_bin), e.peak);
          checkOutput("dv_cycle", longint'(cyc), e.dv_cyc);
        end
      end
    end
  end

  // Watchdog so a stuck design still ends the run
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", checks_passed, checks_total);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    rst = 1'b1;
    fft_out_data = 1'b0;
    Iout = '0;
    Qout = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ac", longint'(AC_component), 0);
    checkOutput("reset_dc", longint'(DC_component), 0);
    checkOutput("reset_peak", longint'(peak_bin), BIN_LO);
    checkOutput("reset_dv", longint'(new_comp_DV), 0);
    checkOutput("reset_pdb_done", longint'(pdb_done), 1);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single bin-0 value");
    clearFrame();
    frame_i[0] = 1000;
    frame_q[0] = -500;
    applyStimulus(0, -1);

    $display("[TB] peak selection");
    peakFrame();
    applyStimulus(0, -1);

    $display("[TB] saturation");
    clearFrame();
    frame_i[0] = -8388608;
    frame_q[0] = -8388608;
    applyStimulus(0, -1);

    $display("[TB] gapped stream");
    peakFrame();
    applyStimulus(3, -1);

    $display("[TB] tie rule");
    clearFrame();
    frame_i[20] = 500;
    frame_i[30] = -200;
    frame_q[30] = 300;
    applyStimulus(0, -1);

    $display("[TB] random frames");
    randomFrame(1000000);
    applyStimulus(0, -1);
    randomFrame(8388608);
    applyStimulus(2, -1);
    randomFrame(3000);
    applyStimulus(1, -1);

    $display("[TB] reset mid-frame");
    randomFrame(2000000);
    applyStimulus(1, 500);
    randomFrame(500000);
    applyStimulus(0, -1);

    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("scoreboard_drained", longint'(sb.size()), 0);
    checkOutput("result_pulse_count", longint'(dv_seen), longint'(frames_sent));

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
